instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, independent of clk.
REQ-003 PC_Write  input  1  1 = advance PC by 4; 0 = hold PC (load-use stall).
REQ-004 PCSrc  input  1  1 = redirect PC to branch_target (taken branch or jump).
REQ-005 branch_target  input  64  redirect address.
REQ-006 imem_we  input  1  instruction-memory byte write enable (program load).
REQ-007 imem_addr  input  6  byte address for the write.
REQ-008 imem_wdata  input  8  byte to write.
REQ-009 instruction  output  32  instruction word at the current PC; feeds the IF/ID pipeline register.
REQ-010 PC_Out  output  64  current PC; feeds the IF/ID pipeline register.
REQ-011 misalign_fault  output  1  sticky flag: a misaligned redirect occurred.
REQ-012 fetch_count  output  32  count of PC advances and redirects (see Configuration).
REQ-013 stall_count  output  32  count of held cycles (see Configuration).

Function
REQ-014 PC register, 64 bits; PC_Out SHALL equal the register directly, with no extra latency.
REQ-015 Per rising edge, priority: PCSrc=1 -> PC <= {branch_target[63:2],2'b00}; else PC_Write=1 -> PC <= PC+4; else PC holds.
REQ-016 PCSrc SHALL override PC_Write=0, so a redirect during a stall is taken.
REQ-017 PC+4 SHALL wrap modulo 2^64, with no carry-out or flag.
REQ-018 Instruction memory: 64 bytes, byte-addressed, 16 words.
REQ-019 instruction = {mem[4k+3],mem[4k+2],mem[4k+1],mem[4k]} with k=PC[5:2] (little-endian).
REQ-020 The instruction read SHALL be combinational from PC; PC bits above [5] alias.
REQ-021 imem_we=1 at a rising edge SHALL write imem_wdata to mem[imem_addr].
REQ-022 If the written byte lies in the current word, instruction SHALL show the old value before the edge and the new value after it.
REQ-023 If branch_target[1:0]!=0 with PCSrc=1, the aligned target is still loaded and misalign_fault SHALL set at that edge.
REQ-024 misalign_fault SHALL remain set until reset.
REQ-025 Memory writes and PC updates in the same cycle are independent; both SHALL take effect.

Reset
REQ-026 While reset=0: PC=0, misalign_fault=0, fetch_count=0, stall_count=0.
REQ-027 Assertion of reset mid-operation SHALL take effect without waiting for a clock edge.
REQ-028 Memory contents SHALL NOT be cleared by reset; program load survives reset.
REQ-029 On the first rising edge after reset returns to 1, the normal update rule applies; PC=0 is presented for at least the cycle following deassertion.

Configuration
REQ-030 Macro IFETCH_PERF_CNT_EN: when defined, fetch_count increments on each edge where PCSrc=1 or PC_Write=1.
REQ-031 When IFETCH_PERF_CNT_EN is defined, stall_count increments on each edge where PCSrc=0 and PC_Write=0.
REQ-032 When IFETCH_PERF_CNT_EN is defined, both counters saturate at 32'hFFFFFFFF and never wrap.
REQ-033 When IFETCH_PERF_CNT_EN is undefined, fetch_count and stall_count are constant 0, no counter flops exist, and the ports remain present.

Verification
REQ-034 Load bytes 0x13,0x05,0x10,0x00 at addresses 0-3; release reset -> PC_Out=0, instruction=32'h00100513.
REQ-035 Hold PC_Write=1 for 3 edges -> PC_Out 4,8,12; then hold PC_Write=0 for 2 edges -> PC_Out stays 12; with macro enabled, fetch_count=3 and stall_count=2.
REQ-036 At PC=12 with PC_Write=0 and PCSrc=1, branch_target=64'h40 -> next PC_Out=64'h40 and instruction=word 0 (aliasing).
REQ-037 PCSrc=1, branch_target=64'h26 -> PC_Out=64'h24 and misalign_fault=1; the fault persists through later branches; it clears only when reset is driven to 0.
REQ-038 PC=64'hFFFFFFFFFFFFFFFC with PC_Write=1 -> PC_Out=0 after the edge.
REQ-039 Drive reset=0 between edges while PC=8 -> PC_Out=0 immediately, counters=0, and memory still returns 32'h00100513 at PC=0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: PC control and program-load inputs toward the fetch unit, plus IF/ID outputs and perf counters.
interface instruction_fetch_if;
  logic        PC_Write;
  logic        PCSrc;
  logic [63:0] branch_target;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [7:0]  imem_wdata;
  logic [31:0] instruction;
  logic [63:0] PC_Out;
  logic        misalign_fault;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  modport master (
    output PC_Write, PCSrc, branch_target, imem_we, imem_addr, imem_wdata,
    input  instruction, PC_Out, misalign_fault, fetch_count, stall_count
  );

  modport slave (
    input  PC_Write, PCSrc, branch_target, imem_we, imem_addr, imem_wdata,
    output instruction, PC_Out, misalign_fault, fetch_count, stall_count
  );
endinterface

// File: rtl/instruction_fetch.sv
// IF stage: 64-bit PC with redirect/advance/hold, 64-byte byte-writable imem read combinationally (0-cycle), no backpressure.
// Optional perf counters enabled by macro IFETCH_PERF_CNT_EN; otherwise counter ports are tied to 0.
module instruction_fetch (
  input logic             clk,
  input logic             reset,
  instruction_fetch_if.slave bus
);

  logic [63:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic [7:0]  mem_q [0:63];

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    if (bus.PCSrc) begin
      pc_d = {bus.branch_target[63:2], 2'b00};
      if (bus.branch_target[1:0] != 2'b00) begin
        fault_d = 1'b1;
      end
    end else if (bus.PC_Write) begin
      pc_d = pc_q + 64'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= 64'd0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // Memory sits outside the reset domain so a program loaded under reset survives it.
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      mem_q[bus.imem_addr] <= bus.imem_wdata;
    end
  end

  assign bus.instruction = {mem_q[{pc_q[5:2], 2'd3}], mem_q[{pc_q[5:2], 2'd2}],
                            mem_q[{pc_q[5:2], 2'd1}], mem_q[{pc_q[5:2], 2'd0}]};
  assign bus.PC_Out         = pc_q;
  assign bus.misalign_fault = fault_q;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.PCSrc || bus.PC_Write) begin
      if (fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
    end else begin
      if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.fetch_count = fetch_cnt_q;
  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.fetch_count = 32'd0;
  assign bus.stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch with an abstract PC/memory model and directed literal checkpoints.
module tb_instruction_fetch;

  logic clk;
  logic reset;
  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [63:0] m_pc;
  logic        m_fault;
  logic [31:0] m_fc, m_sc;
  logic [7:0]  m_mem [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [63:0] pc);
    int k;
    k = int'(pc % 64) / 4;
    return {m_mem[4*k+3], m_mem[4*k+2], m_mem[4*k+1], m_mem[4*k]};
  endfunction

  // Reference model: architectural PC rules and counters.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = '0; m_fault = 1'b0; m_fc = '0; m_sc = '0;
    end else begin
      if (bus.PCSrc) begin
        m_pc = bus.branch_target - (bus.branch_target % 4);
        if (bus.branch_target % 4 != 0) m_fault = 1'b1;
      end else if (bus.PC_Write) begin
        m_pc = m_pc + 64'd4;
      end
`ifdef IFETCH_PERF_CNT_EN
      if (bus.PCSrc || bus.PC_Write) begin
        if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      end else begin
        if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      end
`endif
    end
  end

  always @(posedge clk) begin
    if (bus.imem_we) m_mem[bus.imem_addr] = bus.imem_wdata;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", bus.PC_Out, m_pc);
      chk("instr", {32'd0, bus.instruction}, {32'd0, model_word(m_pc)});
      chk("fault", {63'd0, bus.misalign_fault}, {63'd0, m_fault});
      chk("fetch_cnt", {32'd0, bus.fetch_count}, {32'd0, m_fc});
      chk("stall_cnt", {32'd0, bus.stall_count}, {32'd0, m_sc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pw, input logic src, input logic [63:0] bt);
    bus.PC_Write = pw;
    bus.PCSrc = src;
    bus.branch_target = bt;
    bus.imem_we = 1'b0;
  endtask

  task automatic load_program();
    logic [7:0] prog [4];
    prog[0] = 8'h13; prog[1] = 8'h05; prog[2] = 8'h10; prog[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      bus.imem_we = 1'b1;
      bus.imem_addr = 6'(i);
      bus.imem_wdata = prog[i];
      tick();
    end
    bus.imem_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.PC_Write = 1'b0; bus.PCSrc = 1'b0; bus.branch_target = '0;
    bus.imem_we = 1'b0; bus.imem_addr = '0; bus.imem_wdata = '0;
    #2;
    chk("reset_pc", bus.PC_Out, 64'd0);
    chk("reset_fault", {63'd0, bus.misalign_fault}, 64'd0);

    for (int i = 0; i < 64; i++) begin
      bus.imem_we = 1'b1;
      bus.imem_addr = 6'(i);
      bus.imem_wdata = 8'($urandom);
      tick();
    end
    load_program();
    chk_en = 1'b1;

    // Release reset and start advancing in the same gap between edges.
    reset = 1'b1;
    drive(1'b1, 1'b0, '0);
    #1;
    chk("release_pc", bus.PC_Out, 64'd0);
    chk("release_instr", {32'd0, bus.instruction}, 64'h0010_0513);
    tick(); chk("adv1", bus.PC_Out, 64'd4);
    tick(); chk("adv2", bus.PC_Out, 64'd8);
    tick(); chk("adv3", bus.PC_Out, 64'd12);
    drive(1'b0, 1'b0, '0);
    tick(); tick();
    chk("stall_pc", bus.PC_Out, 64'd12);
`ifdef IFETCH_PERF_CNT_EN
    chk("fetch_cnt_lit", {32'd0, bus.fetch_count}, 64'd3);
    chk("stall_cnt_lit", {32'd0, bus.stall_count}, 64'd2);
`else
    chk("fetch_cnt_lit", {32'd0, bus.fetch_count}, 64'd0);
    chk("stall_cnt_lit", {32'd0, bus.stall_count}, 64'd0);
`endif

    drive(1'b0, 1'b1, 64'h40);
    tick();
    chk("redirect_stall_pc", bus.PC_Out, 64'h40);
    chk("alias_instr", {32'd0, bus.instruction}, 64'h0010_0513);
    chk("no_fault_yet", {63'd0, bus.misalign_fault}, 64'd0);

    // Write into the word currently being fetched.
    drive(1'b0, 1'b0, '0);
    bus.imem_we = 1'b1; bus.imem_addr = 6'd1; bus.imem_wdata = 8'hAA;
    #1;
    chk("wr_before_edge", {32'd0, bus.instruction}, 64'h0010_0513);
    tick();
    chk("wr_after_edge", {32'd0, bus.instruction}, 64'h0010_AA13);
    bus.imem_wdata = 8'h05;
    tick();
    bus.imem_we = 1'b0;

    drive(1'b0, 1'b1, 64'h26);
    tick();
    chk("misalign_pc", bus.PC_Out, 64'h24);
    chk("misalign_fault", {63'd0, bus.misalign_fault}, 64'd1);
    drive(1'b1, 1'b1, 64'h8);
    tick();
    chk("fault_sticky_pc", bus.PC_Out, 64'h8);
    chk("fault_sticky", {63'd0, bus.misalign_fault}, 64'd1);

    drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("top_pc", bus.PC_Out, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1'b1, 1'b0, '0);
    tick();
    chk("wrap_pc", bus.PC_Out, 64'd0);

    for (int c = 0; c < 600; c++) begin
      bus.PC_Write = ($urandom % 4) != 0;
      bus.PCSrc = ($urandom % 8) == 0;
      case ($urandom % 4)
        0: bus.branch_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
        1: bus.branch_target = 64'($urandom % 256);
        default: bus.branch_target = {$urandom, $urandom};
      endcase
      bus.imem_we = ($urandom % 3) == 0;
      bus.imem_addr = 6'($urandom);
      bus.imem_wdata = 8'($urandom);
      tick();
    end

    drive(1'b0, 1'b0, '0);
    load_program();
    drive(1'b0, 1'b1, 64'h8);
    tick();
    drive(1'b1, 1'b0, '0);
    chk("pre_reset_pc", bus.PC_Out, 64'h8);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_pc", bus.PC_Out, 64'd0);
    chk("async_reset_fault", {63'd0, bus.misalign_fault}, 64'd0);
    chk("async_reset_fcnt", {32'd0, bus.fetch_count}, 64'd0);
    chk("async_reset_scnt", {32'd0, bus.stall_count}, 64'd0);
    chk("mem_survives", {32'd0, bus.instruction}, 64'h0010_0513);
    tick();
    reset = 1'b1;
    #1;
    chk("post_release_pc", bus.PC_Out, 64'd0);
    tick();
    chk("post_release_adv", bus.PC_Out, 64'd4);
    tick();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
